exec_pipe: RTL and testbench

Two-stage issue/execute pipeline that drives the ALU. Decoded operations are accepted over a valid/ready handshake. The block reads operands from an internal register file, presents them with the opcode to the ALU, and writes the ALU result back. Condition results are latched into a condition register for the branch unit. It sits between the instruction decoder and the ALU; the ALU instance lives outside this block.

---
 rtl/exec_pipe_pkg.sv | 42 ++++
 rtl/exec_pipe_regfile.sv | 49 ++++
 rtl/exec_pipe.sv | 133 +++++++++++++
 tb/tb_exec_pipe.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pipe_pkg.sv
// Shared opcode and condition constants for the issue/execute pipeline, plus
// the op-class decodes (register-writing op, rs0/rs1 usage).
package exec_pipe_pkg;

  // ALU opcodes (4-bit, as presented on o_alu_do)
  localparam logic [3:0] ALU_NOP = 4'h0;
  localparam logic [3:0] ALU_ADD = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_AND = 4'h3;
  localparam logic [3:0] ALU_OR  = 4'h4;
  localparam logic [3:0] ALU_XOR = 4'h5;
  localparam logic [3:0] ALU_MOV = 4'h6;
  localparam logic [3:0] ALU_LSR = 4'h7;
  localparam logic [3:0] ALU_LSL = 4'h8;
  localparam logic [3:0] ALU_ASR = 4'h9;
  localparam logic [3:0] ALU_ASL = 4'hA;
  localparam logic [3:0] ALU_CND = 4'hB;

  // Condition codes latched for the branch unit
  localparam logic [1:0] CND_EQ   = 2'd0;
  localparam logic [1:0] CND_MORE = 2'd1;
  localparam logic [1:0] CND_LESS = 2'd2;

  // Every op except CND and NOP writes its destination register
  function automatic logic alu_writes(input logic [3:0] op);
    return (op != ALU_NOP) && (op != ALU_CND);
  endfunction

  // NOP is the only op that ignores rs0
  function automatic logic reads_rs0(input logic [3:0] op);
    return op != ALU_NOP;
  endfunction

  // Single-operand ops ignore rs1
  function automatic logic reads_rs1(input logic [3:0] op);
    case (op)
      ALU_MOV, ALU_LSR, ALU_LSL, ALU_ASR, ALU_ASL: return 1'b0;
      default:                                     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/exec_pipe_regfile.sv
// NREG x SIZE register file: write-back and external write ports (external
// wins on the same address), two write-through operand read ports and an
// array-only asynchronous debug read port. Async active-high reset clears it.
module exec_pipe_regfile #(
  parameter  int unsigned SIZE = 8,
  parameter  int unsigned NREG = 8,
  localparam int unsigned RW   = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wb_en_i,
  input  logic [RW-1:0]   wb_addr_i,
  input  logic [SIZE-1:0] wb_data_i,
  input  logic            ext_en_i,
  input  logic [RW-1:0]   ext_addr_i,
  input  logic [SIZE-1:0] ext_data_i,
  input  logic [RW-1:0]   ra0_addr_i,
  output logic [SIZE-1:0] ra0_data_o,
  input  logic [RW-1:0]   ra1_addr_i,
  output logic [SIZE-1:0] ra1_data_o,
  input  logic [RW-1:0]   dbg_addr_i,
  output logic [SIZE-1:0] dbg_data_o
);

  logic [SIZE-1:0] mem_q [NREG];

  // Array update; the external write is applied last so it wins a collision
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      if (wb_en_i)  mem_q[wb_addr_i]  <= wb_data_i;
      if (ext_en_i) mem_q[ext_addr_i] <= ext_data_i;
    end
  end

  // Operand reads see this edge's writes, with external ahead of write-back
  always_comb begin
    ra0_data_o = mem_q[ra0_addr_i];
    if (wb_en_i  && (wb_addr_i  == ra0_addr_i)) ra0_data_o = wb_data_i;
    if (ext_en_i && (ext_addr_i == ra0_addr_i)) ra0_data_o = ext_data_i;
    ra1_data_o = mem_q[ra1_addr_i];
    if (wb_en_i  && (wb_addr_i  == ra1_addr_i)) ra1_data_o = wb_data_i;
    if (ext_en_i && (ext_addr_i == ra1_addr_i)) ra1_data_o = ext_data_i;
  end

  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/exec_pipe.sv
// Two-stage issue/execute pipeline in front of an external combinational ALU.
// EX stage drives the ALU; WB stage writes the result back to the register
// file; CND results latch into o_cnd.
// Optional build macro FORWARD_EN: bypass i_alu_out to the operand read so
// dependent back-to-back ops issue without a stall. Undefined: a RAW hazard
// on the EX-stage writer drops o_ready for one cycle.
module exec_pipe
  import exec_pipe_pkg::*;
#(
  parameter  int unsigned SIZE = 8,
  parameter  int unsigned NREG = 8,
  localparam int unsigned RW   = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [3:0]      i_op,
  input  logic [RW-1:0]   i_rd,
  input  logic [RW-1:0]   i_rs0,
  input  logic [RW-1:0]   i_rs1,
  input  logic            i_wr_en,
  input  logic [RW-1:0]   i_wr_addr,
  input  logic [SIZE-1:0] i_wr_data,
  output logic [3:0]      o_alu_do,
  output logic [SIZE-1:0] o_alu_reg0,
  output logic [SIZE-1:0] o_alu_reg1,
  input  logic [SIZE-1:0] i_alu_out,
  output logic [1:0]      o_cnd,
  output logic            o_wb_valid,
  input  logic [RW-1:0]   i_dbg_addr,
  output logic [SIZE-1:0] o_dbg_data
);

  logic            ex_valid_q, ex_valid_d;
  logic [3:0]      ex_op_q,    ex_op_d;
  logic [RW-1:0]   ex_rd_q,    ex_rd_d;
  logic [SIZE-1:0] ex_a_q,     ex_a_d;
  logic [SIZE-1:0] ex_b_q,     ex_b_d;
  logic            wb_valid_q, wb_valid_d;
  logic [RW-1:0]   wb_rd_q,    wb_rd_d;
  logic [SIZE-1:0] wb_data_q,  wb_data_d;
  logic [1:0]      cnd_q,      cnd_d;

  logic [SIZE-1:0] rf_rd0, rf_rd1, opa, opb;
  logic            ex_writes, hit0, hit1, accept;

  exec_pipe_regfile #(.SIZE(SIZE), .NREG(NREG)) u_regfile (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .wb_en_i    (wb_valid_q),
    .wb_addr_i  (wb_rd_q),
    .wb_data_i  (wb_data_q),
    .ext_en_i   (i_wr_en),
    .ext_addr_i (i_wr_addr),
    .ext_data_i (i_wr_data),
    .ra0_addr_i (i_rs0),
    .ra0_data_o (rf_rd0),
    .ra1_addr_i (i_rs1),
    .ra1_data_o (rf_rd1),
    .dbg_addr_i (i_dbg_addr),
    .dbg_data_o (o_dbg_data)
  );

  // RAW detection against the op currently in EX (only sources the op reads)
  assign ex_writes = ex_valid_q && alu_writes(ex_op_q);
  assign hit0 = ex_writes && reads_rs0(i_op) && (i_rs0 == ex_rd_q);
  assign hit1 = ex_writes && reads_rs1(i_op) && (i_rs1 == ex_rd_q);

`ifdef FORWARD_EN
  assign o_ready = !i_rst;
  assign opa = hit0 ? i_alu_out : rf_rd0;
  assign opb = hit1 ? i_alu_out : rf_rd1;
`else
  assign o_ready = !i_rst && !(hit0 || hit1);
  assign opa = rf_rd0;
  assign opb = rf_rd1;
`endif

  assign accept = i_valid && o_ready;

  // Next state: EX takes the accepted op or a bubble; WB and CND take EX results
  always_comb begin
    ex_valid_d = accept;
    ex_op_d    = ex_op_q;
    ex_rd_d    = ex_rd_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    if (accept) begin
      ex_op_d = i_op;
      ex_rd_d = i_rd;
      ex_a_d  = opa;
      ex_b_d  = opb;
    end
    wb_valid_d = ex_writes;
    wb_rd_d    = ex_rd_q;
    wb_data_d  = i_alu_out;
    cnd_d      = cnd_q;
    if (ex_valid_q && (ex_op_q == ALU_CND)) cnd_d = i_alu_out[1:0];
  end

  // Pipeline registers; reset discards everything in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= ALU_NOP;
      ex_rd_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      cnd_q      <= CND_EQ;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_rd_q    <= ex_rd_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      cnd_q      <= cnd_d;
    end
  end

  assign o_alu_do   = ex_valid_q ? ex_op_q : ALU_NOP;
  assign o_alu_reg0 = ex_valid_q ? ex_a_q : '0;
  assign o_alu_reg1 = ex_valid_q ? ex_b_q : '0;
  assign o_cnd      = cnd_q;
  assign o_wb_valid = wb_valid_q;

endmodule

// File: tb/tb_exec_pipe.sv
// Directed bench for exec_pipe with a behavioural ALU closing the loop.
`timescale 1ns/100ps
module tb_exec_pipe;
  import exec_pipe_pkg::*;

  localparam int unsigned SIZE = 8;
  localparam int unsigned NREG = 8;
`ifdef FORWARD_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif

  logic            clk, rst, valid, ready, wr_en, wb_valid;
  logic [3:0]      op, alu_do;
  logic [2:0]      rd, rs0, rs1, wr_addr, dbg_addr;
  logic [SIZE-1:0] wr_data, reg0, reg1, alu_out, dbg_data;
  logic [1:0]      cnd;

  int vectors = 0;
  int miscompares = 0;

  exec_pipe #(.SIZE(SIZE), .NREG(NREG)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_op(op), .i_rd(rd), .i_rs0(rs0), .i_rs1(rs1),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_alu_do(alu_do), .o_alu_reg0(reg0), .o_alu_reg1(reg1),
    .i_alu_out(alu_out), .o_cnd(cnd), .o_wb_valid(wb_valid),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Reference ALU
  always_comb begin
    alu_out = '0;
    case (alu_do)
      ALU_ADD: alu_out = reg0 + reg1;
      ALU_SUB: alu_out = reg0 - reg1;
      ALU_AND: alu_out = reg0 & reg1;
      ALU_OR:  alu_out = reg0 | reg1;
      ALU_XOR: alu_out = reg0 ^ reg1;
      ALU_MOV: alu_out = reg0;
      ALU_LSR: alu_out = reg0 >> 1;
      ALU_LSL: alu_out = reg0 << 1;
      ALU_ASR: alu_out = $unsigned($signed(reg0) >>> 1);
      ALU_ASL: alu_out = reg0 << 1;
      ALU_CND: alu_out = (reg0 > reg1) ? {6'b0, CND_MORE} :
                         (reg0 < reg1) ? {6'b0, CND_LESS} : {6'b0, CND_EQ};
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {24'b0, dbg_data}, {24'b0, exp});
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < NREG; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk(tag, {24'b0, dbg_data}, 32'h0);
    end
  endtask

  task automatic ext_wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  // Present an op and hold it until accepted; reports stall cycles seen
  task automatic issue(input logic [3:0] o, input logic [2:0] d, input logic [2:0] s0,
                       input logic [2:0] s1, output int stalls);
    valid = 1'b1; op = o; rd = d; rs0 = s0; rs1 = s1;
    stalls = 0;
    #1;
    while (!ready && stalls < 8) begin
      stalls++;
      step();
    end
    if (!ready) begin
      chk("issue_timeout", 32'd1, 32'd0);
      valid = 1'b0;
    end else begin
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st, st2;
    logic [7:0] ca [3];
    logic [7:0] cb [3];
    logic [1:0] ce [3];
    ca[0] = 8'd5; cb[0] = 8'd3; ce[0] = CND_MORE;
    ca[1] = 8'd3; cb[1] = 8'd5; ce[1] = CND_LESS;
    ca[2] = 8'd4; cb[2] = 8'd4; ce[2] = CND_EQ;

    rst = 1'b1; valid = 1'b0; op = ALU_NOP; rd = '0; rs0 = '0; rs1 = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
    step(); step();
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'b0, ready}, 32'd1);
    chk("rst_cnd", {30'b0, cnd}, {30'b0, CND_EQ});
    chk("rst_alu_do", {28'b0, alu_do}, {28'b0, ALU_NOP});
    chk("rst_reg0", {24'b0, reg0}, 32'h0);
    chk("rst_reg1", {24'b0, reg1}, 32'h0);
    chk_all_zero("rst_regs");

    // Basic ADD r3 = r1 + r2
    ext_wr(3'd1, 8'd5);
    ext_wr(3'd2, 8'd3);
    issue(ALU_ADD, 3'd3, 3'd1, 3'd2, st);
    valid = 1'b0;
    chk("add_stall", st, 32'd0);
    chk("add_alu_do", {28'b0, alu_do}, {28'b0, ALU_ADD});
    chk("add_reg0", {24'b0, reg0}, 32'd5);
    chk("add_reg1", {24'b0, reg1}, 32'd3);
    chk("add_wb_valid_ex", {31'b0, wb_valid}, 32'd0);
    step();
    chk("add_wb_valid", {31'b0, wb_valid}, 32'd1);
    chk_reg("add_r3_early", 3'd3, 8'd0);
    step();
    chk("add_wb_valid_done", {31'b0, wb_valid}, 32'd0);
    chk_reg("add_r3", 3'd3, 8'd8);

    // Dependent back-to-back ADD/SUB
    issue(ALU_ADD, 3'd3, 3'd1, 3'd2, st);
    issue(ALU_SUB, 3'd4, 3'd3, 3'd1, st2);
    valid = 1'b0;
    chk("dep_first_stall", st, 32'd0);
    chk("dep_stall", st2, EXP_STALL);
    step(); step(); step();
    chk_reg("dep_r4", 3'd4, 8'd3);
    chk_reg("dep_r3", 3'd3, 8'd8);

    // Condition codes
    for (int i = 0; i < 3; i++) begin
      ext_wr(3'd1, ca[i]);
      ext_wr(3'd2, cb[i]);
      issue(ALU_CND, 3'd6, 3'd1, 3'd2, st);
      valid = 1'b0;
      step();
      chk($sformatf("cnd_code_%0d", i), {30'b0, cnd}, {30'b0, ce[i]});
      chk($sformatf("cnd_no_wb_%0d", i), {31'b0, wb_valid}, 32'd0);
    end
    step();
    chk_reg("cnd_r6", 3'd6, 8'd0);

    // External write collides with WB of r3; same-cycle read sees external
    issue(ALU_ADD, 3'd3, 3'd1, 3'd2, st);
    valid = 1'b0;
    step();
    chk("coll_wb_valid", {31'b0, wb_valid}, 32'd1);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hAA;
    valid = 1'b1; op = ALU_MOV; rd = 3'd5; rs0 = 3'd3; rs1 = 3'd0;
    #1;
    chk("coll_ready", {31'b0, ready}, 32'd1);
    step();
    wr_en = 1'b0; valid = 1'b0;
    chk("coll_alu_do", {28'b0, alu_do}, {28'b0, ALU_MOV});
    chk("coll_reg0", {24'b0, reg0}, 32'hAA);
    chk_reg("coll_r3", 3'd3, 8'hAA);
    step(); step();
    chk_reg("coll_r5", 3'd5, 8'hAA);

    // Reset with ops in flight
    issue(ALU_CND, 3'd0, 3'd1, 3'd0, st);
    issue(ALU_ADD, 3'd7, 3'd1, 3'd2, st);
    issue(ALU_SUB, 3'd6, 3'd1, 3'd0, st);
    valid = 1'b0;
    chk("pre_rst_cnd", {30'b0, cnd}, {30'b0, CND_MORE});
    chk("pre_rst_wb_valid", {31'b0, wb_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("mid_rst_cnd", {30'b0, cnd}, {30'b0, CND_EQ});
    chk("mid_rst_alu_do", {28'b0, alu_do}, {28'b0, ALU_NOP});
    chk("mid_rst_ready", {31'b0, ready}, 32'd0);
    chk_all_zero("mid_rst_regs");
    step();
    rst = 1'b0;
    step(); step(); step();
    chk("post_rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk_reg("post_rst_r7", 3'd7, 8'd0);
    chk_reg("post_rst_r6", 3'd6, 8'd0);

    // MOV ignores rs1 for hazards; NOP writes nothing
    ext_wr(3'd1, 8'd9);
    issue(ALU_MOV, 3'd5, 3'd1, 3'd0, st);
    issue(ALU_MOV, 3'd2, 3'd1, 3'd5, st2);
    chk("mov_rs1_no_stall", st2, 32'd0);
    issue(ALU_NOP, 3'd6, 3'd0, 3'd5, st);
    valid = 1'b0;
    chk("nop_stall", st, 32'd0);
    step();
    chk("nop_no_wb", {31'b0, wb_valid}, 32'd0);
    step();
    chk_reg("nop_r6", 3'd6, 8'd0);
    chk_reg("mov_r5", 3'd5, 8'd9);
    chk_reg("mov_r2", 3'd2, 8'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
